// File: rtl/l2_line_adaptor_if.sv
// Cache-side and memory-side signal bundle for the L2 line adaptor.
// The slave modport is the adaptor's view; the master modport drives it.
interface l2_line_adaptor_if #(
  parameter int s_offset = 5,
  parameter int s_beat   = 64
);
  localparam int s_line = 8 * (2 ** s_offset);

  logic              read_i;
  logic              write_i;
  logic [31:0]       address_i;
  logic [s_line-1:0] line_i;
  logic [s_line-1:0] line_o;
  logic              resp_o;
  logic              read_o;
  logic              write_o;
  logic [31:0]       address_o;
  logic [s_beat-1:0] burst_i;
  logic [s_beat-1:0] burst_o;
  logic              resp_i;

  modport slave (
    input  read_i, write_i, address_i, line_i, burst_i, resp_i,
    output line_o, resp_o, read_o, write_o, address_o, burst_o
  );

  modport master (
    output read_i, write_i, address_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, read_o, write_o, address_o, burst_o
  );
endinterface

// File: rtl/l2_line_adaptor.sv
// Converts whole-line cache fill/writeback requests into NB-beat memory bursts.
// All outputs are registered from the next-state values so none depend combinationally on inputs.
module l2_line_adaptor #(
  parameter int s_offset = 5,
  parameter int s_beat   = 64
) (
  input  logic              clk,
  input  logic              rst,
  l2_line_adaptor_if.slave  bus
);
  localparam int s_line = 8 * (2 ** s_offset);
  localparam int nb     = s_line / s_beat;
  localparam int cnt_w  = $clog2(nb);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [cnt_w-1:0]     cnt_r, cnt_s;
  logic [31-s_offset:0] addr_r, addr_s;
  logic [s_line-1:0]    wline_r, wline_s;
  logic [s_line-1:0]    fill_r, fill_s;

  logic                 read_r, read_s;
  logic                 write_r, write_s;
  logic                 resp_r, resp_s;
  logic [31:0]          address_r, address_s;
  logic [s_beat-1:0]    burst_r, burst_s;

  logic                 last_beat_s;
  logic                 addr_unused_s;

  assign last_beat_s   = (cnt_r == cnt_w'(nb - 1));
  assign addr_unused_s = ^bus.address_i[s_offset-1:0];

  // Next-state, counter, latched request and fill-line assembly.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    wline_s = wline_r;
    fill_s  = fill_r;
    case (state_r)
      IDLE: begin
        if (bus.write_i) begin
          state_s = WRITE;
          addr_s  = bus.address_i[31:s_offset];
          wline_s = bus.line_i;
          cnt_s   = {cnt_w{1'b0}};
        end else if (bus.read_i) begin
          state_s = READ;
          addr_s  = bus.address_i[31:s_offset];
          cnt_s   = {cnt_w{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (bus.resp_i) begin
          fill_s[cnt_r*s_beat +: s_beat] = bus.burst_i;
          cnt_s = cnt_r + cnt_w'(1'b1);
          if (last_beat_s) begin
            state_s = DONE;
          end else begin
            state_s = READ;
          end
        end else begin
          state_s = READ;
        end
      end
      WRITE: begin
        if (bus.resp_i) begin
          cnt_s = cnt_r + cnt_w'(1'b1);
          if (last_beat_s) begin
            state_s = DONE;
          end else begin
            state_s = WRITE;
          end
        end else begin
          state_s = WRITE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output values for the upcoming state; registered below.
  always_comb begin
    read_s    = (state_s == READ);
    write_s   = (state_s == WRITE);
    resp_s    = (state_s == DONE);
    address_s = 32'd0;
    burst_s   = {s_beat{1'b0}};
    if ((state_s == READ) || (state_s == WRITE)) begin
      address_s = {addr_s, {s_offset{1'b0}}};
    end else begin
      address_s = 32'd0;
    end
    if (state_s == WRITE) begin
      burst_s = wline_s[cnt_s*s_beat +: s_beat];
    end else begin
      burst_s = {s_beat{1'b0}};
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {cnt_w{1'b0}};
      addr_r    <= {(32 - s_offset){1'b0}};
      wline_r   <= {s_line{1'b0}};
      fill_r    <= {s_line{1'b0}};
      read_r    <= 1'b0;
      write_r   <= 1'b0;
      resp_r    <= 1'b0;
      address_r <= 32'd0;
      burst_r   <= {s_beat{1'b0}};
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      addr_r    <= addr_s;
      wline_r   <= wline_s;
      fill_r    <= fill_s;
      read_r    <= read_s;
      write_r   <= write_s;
      resp_r    <= resp_s;
      address_r <= address_s;
      burst_r   <= burst_s;
    end
  end

  assign bus.line_o    = fill_r;
  assign bus.read_o    = read_r;
  assign bus.write_o   = write_r;
  assign bus.resp_o    = resp_r;
  assign bus.address_o = address_r;
  assign bus.burst_o   = burst_r;
endmodule

// File: tb/tb_l2_line_adaptor.sv
// Self-checking bench for l2_line_adaptor: transaction-level reference model
// compared every cycle, plus hand-computed literal expectations per scenario.
module tb_l2_line_adaptor;
  localparam int SO = 5;
  localparam int SB = 64;
  localparam int SL = 256;
  localparam int NB = 4;
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;
  localparam logic [255:0] L_FILL = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                                     64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
  localparam logic [255:0] L_WB = {64'hDDDD_0000_DDDD_0004, 64'hCCCC_0000_CCCC_0003,
                                   64'hBBBB_0000_BBBB_0002, 64'hAAAA_0000_AAAA_0001};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  l2_line_adaptor_if #(.s_offset(SO), .s_beat(SB)) bus ();

  l2_line_adaptor #(.s_offset(SO), .s_beat(SB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: op 0 = no transaction, 1 = fill, 2 = writeback.
  int           m_op   = 0;
  int           m_cnt  = 0;
  bit           m_done = 1'b0;
  logic [31:0]  m_addr = 32'd0;
  logic [SL-1:0] m_wline = '0;
  logic [SL-1:0] m_fill  = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin : model
    int op, cnt;
    bit done;
    logic [31:0] a;
    logic [SL-1:0] wl, fl;
    op = m_op; cnt = m_cnt; done = m_done; a = m_addr; wl = m_wline; fl = m_fill;
    if (rst) begin
      op = 0; cnt = 0; done = 1'b0; a = 32'd0; wl = '0; fl = '0;
    end else if (done) begin
      done = 1'b0;
    end else if (op == 0) begin
      if (bus.write_i) begin
        op = 2; cnt = 0; a = bus.address_i & LINE_MASK; wl = bus.line_i;
      end else if (bus.read_i) begin
        op = 1; cnt = 0; a = bus.address_i & LINE_MASK;
      end
    end else if (bus.resp_i) begin
      if (op == 1) fl[cnt*SB +: SB] = bus.burst_i;
      cnt = cnt + 1;
      if (cnt == NB) begin
        op = 0; cnt = 0; done = 1'b1;
      end
    end
    m_op <= op; m_cnt <= cnt; m_done <= done; m_addr <= a; m_wline <= wl; m_fill <= fl;
  end

  // Cycle-by-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("read_o",    {255'd0, bus.read_o},  {255'd0, (m_op == 1)});
      chk("write_o",   {255'd0, bus.write_o}, {255'd0, (m_op == 2)});
      chk("resp_o",    {255'd0, bus.resp_o},  {255'd0, m_done});
      chk("address_o", {224'd0, bus.address_o}, {224'd0, (m_op != 0) ? m_addr : 32'd0});
      chk("burst_o",   {192'd0, bus.burst_o},
          {192'd0, (m_op == 2) ? m_wline[m_cnt*SB +: SB] : 64'd0});
      chk("line_o",    bus.line_o, m_fill);
    end
  end

  task automatic start(input bit rd, input bit wr, input logic [31:0] a, input logic [255:0] l);
    @(negedge clk);
    bus.read_i = rd; bus.write_i = wr; bus.address_i = a; bus.line_i = l; bus.resp_i = 1'b0;
    @(negedge clk);
    // Scramble request inputs after acceptance; the transaction must not notice.
    bus.address_i = $urandom;
    bus.line_i = {8{$urandom}};
  endtask

  task automatic feed(input logic [15:0] mask, output int cyc, output logic [63:0] b0,
                      output bit saw_rd, output bit saw_wr);
    int beats;
    beats = 0; cyc = 0; b0 = bus.burst_o; saw_rd = 1'b0; saw_wr = 1'b0;
    while (!bus.resp_o && cyc < 40) begin
      saw_rd |= bus.read_o;
      saw_wr |= bus.write_o;
      bus.resp_i  = (cyc < 16) ? mask[cyc] : 1'b1;
      bus.burst_i = {8{8'hA0 + 8'(beats)}};
      if (bus.resp_i) beats++;
      @(negedge clk);
      cyc++;
    end
    bus.resp_i = 1'b0;
    bus.burst_i = 64'd0;
    if (!bus.resp_o) chk("resp_timeout", {255'd0, bus.resp_o}, {255'd0, 1'b1});
  endtask

  task automatic release_req();
    bus.read_i = 1'b0; bus.write_i = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [63:0] b0;
    bit srd, swr;
    bus.read_i = 1'b0; bus.write_i = 1'b0; bus.address_i = 32'd0; bus.line_i = '0;
    bus.burst_i = 64'd0; bus.resp_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_read_o", {255'd0, bus.read_o}, 256'd0);
    chk("rst_line_o", bus.line_o, 256'd0);
    chk("rst_address_o", {224'd0, bus.address_o}, 256'd0);
    rst = 1'b0;

    // Plain fill.
    start(1'b1, 1'b0, 32'h0000_1234, '0);
    chk("fill_address", {224'd0, bus.address_o}, {224'd0, 32'h0000_1220});
    feed(16'hFFFF, cyc, b0, srd, swr);
    chk("fill_latency", cyc, 4);
    chk("fill_line", bus.line_o, L_FILL);
    chk("fill_saw_rd", {255'd0, srd}, {255'd0, 1'b1});
    release_req();

    // Writeback.
    start(1'b0, 1'b1, 32'h0000_4040, L_WB);
    feed(16'hFFFF, cyc, b0, srd, swr);
    chk("wb_beat0", {192'd0, b0}, {192'd0, 64'hAAAA_0000_AAAA_0001});
    chk("wb_latency", cyc, 4);
    chk("wb_line_kept", bus.line_o, L_FILL);
    chk("wb_saw_rd", {255'd0, srd}, 256'd0);
    release_req();

    // Gapped fill 1,0,0,1,1,0,1.
    start(1'b1, 1'b0, 32'h0000_8FFF, '0);
    chk("gap_address", {224'd0, bus.address_o}, {224'd0, 32'h0000_8FE0});
    feed(16'h0059, cyc, b0, srd, swr);
    chk("gap_latency", cyc, 7);
    chk("gap_line", bus.line_o, L_FILL);
    release_req();

    // Simultaneous read and write: write wins.
    start(1'b1, 1'b1, 32'h0000_0100, L_WB);
    feed(16'hFFFF, cyc, b0, srd, swr);
    chk("both_saw_wr", {255'd0, swr}, {255'd0, 1'b1});
    chk("both_saw_rd", {255'd0, srd}, 256'd0);
    release_req();

    // Reset after two fill beats.
    start(1'b1, 1'b0, 32'h0000_3000, '0);
    bus.resp_i = 1'b1; bus.burst_i = 64'h1111_1111_1111_1111;
    @(negedge clk);
    bus.burst_i = 64'h2222_2222_2222_2222;
    @(negedge clk);
    bus.resp_i = 1'b0; rst = 1'b1; release_req();
    @(negedge clk);
    chk("mid_rst_read_o", {255'd0, bus.read_o}, 256'd0);
    chk("mid_rst_line_o", bus.line_o, 256'd0);
    chk("mid_rst_address_o", {224'd0, bus.address_o}, 256'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    start(1'b1, 1'b0, 32'h0000_5000, '0);
    feed(16'hFFFF, cyc, b0, srd, swr);
    chk("post_rst_latency", cyc, 4);
    chk("post_rst_line", bus.line_o, L_FILL);
    release_req();

    // Back-to-back fills with read_i held through resp_o.
    start(1'b1, 1'b0, 32'h0000_6000, '0);
    feed(16'hFFFF, cyc, b0, srd, swr);
    @(negedge clk);
    chk("b2b_idle_gap", {255'd0, bus.read_o}, 256'd0);
    @(negedge clk);
    chk("b2b_reassert", {255'd0, bus.read_o}, {255'd0, 1'b1});
    feed(16'h00FF, cyc, b0, srd, swr);
    chk("b2b_latency", cyc, 4);
    chk("b2b_line", bus.line_o, L_FILL);
    release_req();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
